// File: rtl/vga_pkg.sv
// Shared encodings for the VGA pattern sequencer: displayed modes, FSM states,
// start-of-frame pixel position and small helpers.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_PATT2 = 2'd0,
    MODE_PATT1 = 2'd1,
    MODE_XOR   = 2'd2,
    MODE_BLANK = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_SHOW  = 2'd0,
    ST_PEND  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam int unsigned SOF_ROW = 0;
  localparam int unsigned SOF_COL = 0;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Auto-cycle order: PATT2 -> PATT1 -> XOR -> PATT2
  function automatic mode_t next_auto(input mode_t m);
    case (m)
      MODE_PATT2: return MODE_PATT1;
      MODE_PATT1: return MODE_XOR;
      default:    return MODE_PATT2;
    endcase
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a debouncer: the level follows the input
// only after DEBOUNCE_CYCLES consecutive synchronised samples that differ from it.
module switch_debounce
  import vga_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sw_i,
  output logic level_o
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= sw_i;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level_o = r_level;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous pattern selector in front of the VGA driver: debounced
// switches or an auto-cycle choose a pattern, swapped only at start of frame.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned FRAMES_PER_MODE = 120,
  parameter int unsigned BLANK_FRAMES    = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       switch1_i,
  input  logic       switch2_i,
  input  logic       auto_i,
  input  logic [8:0] row_i,
  input  logic [9:0] column_i,
  input  logic [2:0] rgb1_i,
  input  logic [2:0] rgb2_i,
  output logic [2:0] rgb_o,
  output logic [1:0] mode_o,
  output logic       busy_o,
  output logic       sof_o
);

  localparam int unsigned   FW         = cnt_width(FRAMES_PER_MODE);
  localparam int unsigned   BW         = cnt_width(BLANK_FRAMES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_MODE - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_FRAMES - 1);

  logic w_sw1;
  logic w_sw2;
  logic w_auto;
  logic w_z;
  mode_t w_req;
  logic [2:0] w_rgb;

  state_t        r_state;
  mode_t         r_cur;
  mode_t         r_tgt;
  mode_t         r_mode;
  mode_t         r_auto_idx;
  logic          r_busy;
  logic          r_z_d;
  logic          r_sof;
  logic [BW-1:0] r_blank_cnt;
  logic [FW-1:0] r_frame_cnt;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sw1 (
    .clk_i(clk_i), .reset_i(reset_i), .sw_i(switch1_i), .level_o(w_sw1)
  );
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sw2 (
    .clk_i(clk_i), .reset_i(reset_i), .sw_i(switch2_i), .level_o(w_sw2)
  );
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_auto (
    .clk_i(clk_i), .reset_i(reset_i), .sw_i(auto_i), .level_o(w_auto)
  );

  assign w_z = (row_i == 9'(SOF_ROW)) && (column_i == 10'(SOF_COL));

  always_comb begin
    w_req = MODE_PATT2;
    if (w_auto)         w_req = r_auto_idx;
    else if (w_sw2)     w_req = MODE_XOR;
    else if (w_sw1)     w_req = MODE_PATT1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= ST_SHOW;
      r_cur       <= MODE_PATT2;
      r_tgt       <= MODE_PATT2;
      r_mode      <= MODE_PATT2;
      r_auto_idx  <= MODE_PATT2;
      r_busy      <= 1'b0;
      r_z_d       <= 1'b0;
      r_sof       <= 1'b0;
      r_blank_cnt <= '0;
      r_frame_cnt <= '0;
    end else begin
      // z holds for a whole pixel; only its rising edge marks the frame start
      r_z_d <= w_z;
      r_sof <= w_z & ~r_z_d;

      if (!w_auto) begin
        r_frame_cnt <= '0;
      end else if (r_sof && (r_state == ST_SHOW)) begin
        if (r_frame_cnt == FRAME_LAST) begin
          r_frame_cnt <= '0;
          r_auto_idx  <= next_auto(r_auto_idx);
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end

      case (r_state)
        ST_SHOW: begin
          if (w_req != r_cur) begin
            r_state <= ST_PEND;
            r_busy  <= 1'b1;
          end
        end
        ST_PEND: begin
          if (r_sof) begin
            if (w_req == r_cur) begin
              r_state <= ST_SHOW;
              r_busy  <= 1'b0;
            end else begin
              r_tgt       <= w_req;
              r_blank_cnt <= '0;
              r_mode      <= MODE_BLANK;
              r_state     <= ST_BLANK;
            end
          end
        end
        ST_BLANK: begin
          if (r_sof) begin
            if (r_blank_cnt == BLANK_LAST) begin
              r_cur       <= r_tgt;
              r_mode      <= r_tgt;
              r_state     <= ST_SHOW;
              r_busy      <= 1'b0;
              r_blank_cnt <= '0;
            end else begin
              r_blank_cnt <= r_blank_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_SHOW;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_rgb = '0;
    if (!reset_i) begin
      case (r_mode)
        MODE_PATT2: w_rgb = rgb2_i;
        MODE_PATT1: w_rgb = rgb1_i;
        MODE_XOR:   w_rgb = rgb1_i ^ rgb2_i;
        default:    w_rgb = '0;
      endcase
    end
  end

  assign rgb_o  = w_rgb;
  assign mode_o = r_mode;
  assign busy_o = r_busy;
  assign sof_o  = r_sof;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer: per-cycle reference model,
// table-driven pattern vectors and directed multi-cycle corner cases.
module tb_vga_pattern_sequencer;

  localparam int DEB  = 4;
  localparam int FPM  = 2;
  localparam int BF   = 1;
  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int FRAME_CYC = COLS * ROWS * 2;

  logic       clk;
  logic       rst;
  logic       sw1, sw2, aut;
  logic [8:0] row;
  logic [9:0] col;
  logic [2:0] rgb1, rgb2;
  logic [2:0] rgb_o;
  logic [1:0] mode_o;
  logic       busy_o;
  logic       sof_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;
  bit rand_rgb = 0;

  vga_pattern_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .FRAMES_PER_MODE(FPM),
    .BLANK_FRAMES(BF)
  ) dut (
    .clk_i(clk), .reset_i(rst), .switch1_i(sw1), .switch2_i(sw2), .auto_i(aut),
    .row_i(row), .column_i(col), .rgb1_i(rgb1), .rgb2_i(rgb2),
    .rgb_o(rgb_o), .mode_o(mode_o), .busy_o(busy_o), .sof_o(sof_o)
  );

  initial begin
    clk = 0;
    forever #10 clk = ~clk;
  end

  // Raster: each pixel lasts two clocks
  initial begin
    int cyc;
    int pix;
    cyc = 0; row = '0; col = '0;
    forever begin
      @(negedge clk);
      cyc++;
      pix = cyc / 2;
      col = 10'(pix % COLS);
      row = 9'((pix / COLS) % ROWS);
      if (rand_rgb) begin
        rgb1 = 3'($urandom);
        rgb2 = 3'($urandom);
      end
    end
  end

  // Reference model: displayed mode, pending flag, blank frames remaining
  int m_disp, m_cur, m_tgt, m_idx, m_fcnt, m_blank_left;
  bit m_pend, m_sof, m_zprev;
  int m_lvl[3], m_run[3], m_s1[3], m_s2[3];

  always @(posedge clk) begin
    int req, raw[3], v;
    bit sof_now, showing, z;
    if (rst) begin
      m_disp = 0; m_cur = 0; m_tgt = 0; m_idx = 0; m_fcnt = 0; m_blank_left = 0;
      m_pend = 0; m_sof = 0; m_zprev = 0;
      for (int i = 0; i < 3; i++) begin
        m_lvl[i] = 0; m_run[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
      end
    end else begin
      sof_now = m_sof;
      showing = !m_pend && (m_blank_left == 0);
      if (m_lvl[2] != 0)      req = m_idx;
      else if (m_lvl[1] != 0) req = 2;
      else if (m_lvl[0] != 0) req = 1;
      else                    req = 0;

      if (m_blank_left > 0) begin
        if (sof_now) begin
          m_blank_left--;
          if (m_blank_left == 0) begin
            m_cur  = m_tgt;
            m_disp = m_tgt;
          end
        end
      end else if (m_pend) begin
        if (sof_now) begin
          m_pend = 0;
          if (req != m_cur) begin
            m_tgt = req;
            m_blank_left = BF;
            m_disp = 3;
          end
        end
      end else if (req != m_cur) begin
        m_pend = 1;
      end

      if (m_lvl[2] == 0) m_fcnt = 0;
      else if (sof_now && showing) begin
        m_fcnt++;
        if (m_fcnt == FPM) begin
          m_fcnt = 0;
          m_idx = (m_idx + 1) % 3;
        end
      end

      raw[0] = int'(sw1); raw[1] = int'(sw2); raw[2] = int'(aut);
      for (int i = 0; i < 3; i++) begin
        v = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
        if (v == m_lvl[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i] = v;
            m_run[i] = 0;
          end
        end
      end

      z = (row == 0) && (col == 0);
      m_sof = z && !m_zprev;
      m_zprev = z;
    end
  end

  function automatic int exp_rgb(input int mode, input int r1, input int r2, input bit rs);
    if (rs) return 0;
    case (mode)
      0: return r2;
      1: return r1;
      2: return r1 ^ r2;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        check("model_mode", int'(mode_o), m_disp);
        check("model_busy", int'(busy_o), int'(m_pend || (m_blank_left > 0)));
        check("model_sof",  int'(sof_o),  int'(m_sof));
        check("model_rgb",  int'(rgb_o),  exp_rgb(m_disp, int'(rgb1), int'(rgb2), rst));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic       s1;
    logic       s2;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [1:0] mode;
    logic [2:0] rgb;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int  n;
    bit  seen;
    bit  seen1, seen2, seen3;

    tbl[0] = '{s1: 1'b1, s2: 1'b1, r1: 3'b101, r2: 3'b011, mode: 2'd2, rgb: 3'b110};
    tbl[1] = '{s1: 1'b0, s2: 1'b1, r1: 3'b111, r2: 3'b001, mode: 2'd2, rgb: 3'b110};
    tbl[2] = '{s1: 1'b0, s2: 1'b0, r1: 3'b100, r2: 3'b110, mode: 2'd0, rgb: 3'b110};
    tbl[3] = '{s1: 1'b1, s2: 1'b0, r1: 3'b010, r2: 3'b111, mode: 2'd1, rgb: 3'b010};
    tbl[4] = '{s1: 1'b0, s2: 1'b0, r1: 3'b101, r2: 3'b011, mode: 2'd0, rgb: 3'b011};

    rst = 1; sw1 = 0; sw2 = 0; aut = 0; rgb1 = 3'b101; rgb2 = 3'b011;
    tick();
    chk_en = 1;
    tick();
    check("reset_rgb", int'(rgb_o), 0);
    check("reset_mode", int'(mode_o), 0);
    rst = 0;
    ticks(2);
    check("post_reset_mode", int'(mode_o), 0);
    check("post_reset_rgb", int'(rgb_o), int'(rgb2));
    check("post_reset_busy", int'(busy_o), 0);

    // 3-cycle glitch must not be accepted
    sw1 = 1; ticks(3); sw1 = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy_o || mode_o != 2'd0) seen = 1;
    end
    check("glitch_ignored", int'(seen), 0);

    // Held switch: 2 sync + 4 debounce samples + 1 FSM register
    sw1 = 1;
    n = 0;
    while (!busy_o && n < 50) begin tick(); n++; end
    check("sw1_busy_latency", n, 7);
    n = 0;
    while (mode_o != 2'd3 && n < 3 * FRAME_CYC) begin tick(); n++; end
    check("blank_reached", int'(mode_o), 3);
    check("blank_busy", int'(busy_o), 1);
    n = 0;
    while (mode_o == 2'd3 && n < 3 * FRAME_CYC) begin tick(); n++; end
    check("blank_len", n, FRAME_CYC);
    check("patt1_after_blank", int'(mode_o), 1);

    foreach (tbl[k]) begin
      sw1 = tbl[k].s1; sw2 = tbl[k].s2; rgb1 = tbl[k].r1; rgb2 = tbl[k].r2;
      ticks(3 * FRAME_CYC + 8);
      check($sformatf("tbl%0d_mode", k), int'(mode_o), int'(tbl[k].mode));
      check($sformatf("tbl%0d_rgb", k), int'(rgb_o), int'(tbl[k].rgb));
      check($sformatf("tbl%0d_busy", k), int'(busy_o), 0);
    end

    // Cancel in PEND: switch returns before the next start of frame
    n = 0;
    while (!sof_o && n < 2 * FRAME_CYC) begin tick(); n++; end
    check("cancel_sof_found", int'(sof_o), 1);
    sw1 = 1;
    ticks(12);
    check("cancel_pend_busy", int'(busy_o), 1);
    sw1 = 0;
    tick();
    n = 0;
    while (!sof_o && n < 2 * FRAME_CYC) begin tick(); n++; end
    tick();
    check("cancel_busy", int'(busy_o), 0);
    check("cancel_mode", int'(mode_o), 0);
    seen = 0;
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      tick();
      if (mode_o == 2'd3) seen = 1;
    end
    check("cancel_no_blank", int'(seen), 0);

    // Auto mode walks all patterns with blanking in between
    rand_rgb = 1;
    aut = 1;
    seen1 = 0; seen2 = 0; seen3 = 0;
    for (int i = 0; i < 14 * FRAME_CYC; i++) begin
      tick();
      if (mode_o == 2'd1) seen1 = 1;
      if (mode_o == 2'd2) seen2 = 1;
      if (mode_o == 2'd3) seen3 = 1;
    end
    check("auto_saw_all", int'({seen1, seen2, seen3}), 7);
    aut = 0;

    // Reset pulse during BLANK
    n = 0;
    while (busy_o && n < 4 * FRAME_CYC) begin tick(); n++; end
    if (mode_o == 2'd2) sw1 = 1; else sw2 = 1;
    n = 0;
    while (mode_o != 2'd3 && n < 4 * FRAME_CYC) begin tick(); n++; end
    check("rst_blank_reached", int'(mode_o), 3);
    rst = 1;
    tick();
    check("rst_mode", int'(mode_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_sof", int'(sof_o), 0);
    check("rst_rgb", int'(rgb_o), 0);
    rst = 0;
    ticks(3 * FRAME_CYC);

    // Randomised segments; some shorter than the debounce window
    for (int s = 0; s < 40; s++) begin
      sw1 = 1'($urandom);
      sw2 = 1'($urandom_range(0, 3) == 0);
      aut = 1'($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) ticks(int'($urandom_range(1, DEB)));
      else ticks(int'($urandom_range(10, 2 * FRAME_CYC)));
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
